// File: rtl/boom_mem_trace_pkg.sv
// Shared types for the memory-request trace buffer: entry layout, FSM states, drop-counter helper.
package boom_mem_trace_pkg;

   localparam int TRACE_ADDR_WIDTH  = 32;
   localparam int TRACE_DATA_WIDTH  = 64;
   localparam int TRACE_BE_WIDTH    = TRACE_DATA_WIDTH / 8;
   localparam int STOP_ADDR_WIDTH   = 31;
   localparam int DROP_CNT_WIDTH    = 16;

   typedef struct packed {
      logic                        we;
      logic [TRACE_ADDR_WIDTH-1:0] addr;
      logic [TRACE_BE_WIDTH-1:0]   be;
      logic [TRACE_DATA_WIDTH-1:0] data;
   } trace_entry_t;

   localparam int TRACE_ENTRY_WIDTH = $bits(trace_entry_t);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trace_state_e;

   localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

   function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc_drop(input logic [DROP_CNT_WIDTH-1:0] cnt);
      return (cnt == DROP_CNT_MAX) ? cnt : cnt + 16'd1;
   endfunction

endpackage

// File: rtl/boom_mem_trace_fifo.sv
// Trace entry FIFO: unreset storage, reset pointers/level; push while full is only taken
// alongside a pop, pop while empty is ignored.
module boom_mem_trace_fifo
   import boom_mem_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  trace_entry_t             push_data_i,
   input  logic                     pop_i,
   output trace_entry_t             head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   trace_entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   push_acc;
   logic                   pop_acc;

   assign full_o   = (level_q == LVL_W'(DEPTH));
   assign empty_o  = (level_q == '0);
   assign pop_acc  = pop_i & ~empty_o;
   assign push_acc = push_i & (~full_o | pop_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_acc, pop_acc})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Storage is unreset, so the head is masked to zero whenever nothing is valid.
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/boom_mem_trace_buf.sv
// Memory-request trace buffer: captures write requests (reads too with BOOM_MEM_TRACE_READS_EN)
// into a FIFO until the end-of-benchmark MMIO write, then drains and flags done.
//
//   state | meaning
//   RUN   | capturing qualified requests, watching for the stop write
//   DRAIN | capture closed, consumer emptying the FIFO
//   DONE  | FIFO empty after stop; held until reset
module boom_mem_trace_buf
   import boom_mem_trace_pkg::*;
#(
   parameter int          ADDR_WIDTH = TRACE_ADDR_WIDTH,
   parameter int          DATA_WIDTH = TRACE_DATA_WIDTH,
   parameter int          DEPTH      = 16,
   parameter logic [30:0] STOP_ADDR  = 31'h1000_0000
) (
   input  logic                      clock,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic                      mmio_aw_valid_i,
   input  logic [30:0]               mmio_aw_addr_i,
   output logic                      trace_valid_o,
   input  logic                      trace_ready_i,
   output trace_entry_t              trace_entry_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic [15:0]               drop_cnt_o,
   output logic                      done_o
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   trace_state_e                state_q;
   logic                        done_q;
   logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

   logic                        req_qual;
   logic                        capture;
   logic                        pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        stop_hit;
   logic                        drained;
   trace_entry_t                cap_entry;

`ifdef BOOM_MEM_TRACE_READS_EN
   assign req_qual = req_i;
`else
   assign req_qual = req_i & we_i;
`endif

   assign capture = (state_q == RUN) & req_qual;
   assign pop     = trace_valid_o & trace_ready_i;

   always_comb begin
      cap_entry      = '0;
      cap_entry.we   = we_i;
      cap_entry.addr = addr_i;
      cap_entry.be   = be_i;
      cap_entry.data = we_i ? data_i : '0;
   end

   boom_mem_trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .rst_ni      (rst_ni),
      .push_i      (capture),
      .push_data_i (cap_entry),
      .pop_i       (pop),
      .head_o      (trace_entry_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (level_o)
   );

   assign trace_valid_o = ~fifo_empty;

   // Full with no pop in the same cycle: the capture is lost and counted.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (capture && fifo_full && !pop) drop_cnt_d = sat_inc_drop(drop_cnt_q);
   end

   always_ff @(posedge clock or negedge rst_ni) begin
      if (!rst_ni) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;

   assign stop_hit = mmio_aw_valid_i & (mmio_aw_addr_i == STOP_ADDR);
   // Nothing is pushed in DRAIN, so the FIFO is empty after this edge when it is empty
   // now or its last entry is being popped; DONE then coincides with level_o reaching 0.
   assign drained  = (level_o == '0) | ((level_o == LVL_W'(1)) & pop);

   always_ff @(posedge clock or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (stop_hit) state_q <= DRAIN;
            end
            DRAIN: begin
               if (drained) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= RUN;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign done_o = done_q;

endmodule
